// File: rtl/ysyx_25040118_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_25040118_pkg
//  Description : Shared constants and types for the ysyx_25040118 core slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package ysyx_25040118_pkg;

    typedef enum logic [1:0] {
        IFU_REQ  = 2'd0,
        IFU_WAIT = 2'd1,
        IFU_HOLD = 2'd2
    } ifu_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    // Retiring this encoding raises the IFU halt input.
    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

endpackage : ysyx_25040118_pkg
`default_nettype wire

// File: rtl/ysyx_25040118_ifu_if.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_25040118_ifu_if
//  Description : Instruction-memory read bus (request/response) between the
//                IFU (master) and the instruction memory (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface ysyx_25040118_ifu_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            resp_valid;
    logic [XLEN-1:0] resp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  resp_valid,
        input  resp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output resp_valid,
        output resp_data
    );

endinterface : ysyx_25040118_ifu_if
`default_nettype wire

// File: rtl/ysyx_25040118_ifu.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_25040118_ifu
//  Description : Instruction fetch unit; one fetch in flight, REQ/WAIT/HOLD FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_25040118_ifu
    import ysyx_25040118_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    ysyx_25040118_ifu_if.master           imem,
    output logic                          inst_valid,
    input  wire logic                     inst_ready,
    output logic [XLEN-1:0]               inst,
    output logic [XLEN-1:0]               inst_pc,
    input  wire logic                     redirect_valid,
    input  wire logic [XLEN-1:0]          redirect_pc,
    input  wire logic                     halt,
    output logic                          halted
);

    ifu_state_e      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic            drop_q, drop_d;
    logic            halt_q, halt_d;
    logic            req_valid_q, req_valid_d;
    logic            inst_valid_q, inst_valid_d;
    logic            halted_q, halted_d;
    logic            req_fire;

    assign req_fire = req_valid_q && imem.req_ready;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        req_pc_d  = req_pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        drop_d    = drop_q;
        halt_d    = halt_q | halt;

        unique case (state_q)
            IFU_REQ: begin
                if (req_fire) begin
                    req_pc_d = pc_q;
                    state_d  = IFU_WAIT;
                end
            end
            IFU_WAIT: begin
                if (imem.resp_valid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = IFU_REQ;
                    end else begin
                        inst_d    = imem.resp_data;
                        inst_pc_d = req_pc_q;
                        pc_d      = req_pc_q + XLEN'(4);
                        state_d   = IFU_HOLD;
                    end
                end
            end
            IFU_HOLD: begin
                if (inst_ready) begin
                    state_d = IFU_REQ;
                end
            end
            default: begin
                state_d = IFU_REQ;
            end
        endcase

        // A redirect overrides everything above; a word already in flight is
        // marked for discard so its late response cannot be delivered.
        if (redirect_valid) begin
            pc_d      = {redirect_pc[XLEN-1:2], 2'b00};
            inst_d    = inst_q;
            inst_pc_d = inst_pc_q;
            unique case (state_q)
                IFU_WAIT: begin
                    if (imem.resp_valid) begin
                        drop_d  = 1'b0;
                        state_d = IFU_REQ;
                    end else begin
                        drop_d  = 1'b1;
                        state_d = IFU_WAIT;
                    end
                end
                IFU_REQ: begin
                    if (req_fire) begin
                        drop_d  = 1'b1;
                        state_d = IFU_WAIT;
                    end else begin
                        state_d = IFU_REQ;
                    end
                end
                default: begin
                    state_d = IFU_REQ;
                end
            endcase
        end

        req_valid_d  = (state_d == IFU_REQ) && !halt_d;
        inst_valid_d = (state_d == IFU_HOLD);
        halted_d     = (state_d == IFU_REQ) && halt_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IFU_REQ;
            pc_q         <= RESET_PC;
            req_pc_q     <= '0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            drop_q       <= 1'b0;
            halt_q       <= 1'b0;
            req_valid_q  <= 1'b0;
            inst_valid_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            drop_q       <= drop_d;
            halt_q       <= halt_d;
            req_valid_q  <= req_valid_d;
            inst_valid_q <= inst_valid_d;
            halted_q     <= halted_d;
        end
    end

    assign imem.req_valid = req_valid_q;
    assign imem.req_addr  = {pc_q[XLEN-1:2], 2'b00};
    assign inst_valid     = inst_valid_q;
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign halted         = halted_q;

endmodule : ysyx_25040118_ifu
`default_nettype wire
